edge_window_ctrl: RTL and testbench

Frame/line sequencer for the Sobel edge-check datapath. It tracks pixel coordinates from the frame sync and data-enable strobes, and decides when the 3x3 window built from the two line buffers holds real pixels. It masks the border rows and columns that are still priming, and aligns a valid strobe with the datapath latency. It also owns the edge threshold: the threshold is double-buffered, so a mid-frame write takes effect only at the next frame start.

---
 rtl/edge_window_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_edge_window_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_window_ctrl.sv
// edge_window_ctrl: frame/line sequencer for the Sobel edge-check datapath.
// It tracks pixel coordinates from RGB_VS/RGB_DE and flags when the 3x3
// window holds real pixels. Border rows/columns are masked while the line
// buffers prime. The valid strobe is aligned to the datapath latency. It also
// owns a double-buffered edge threshold.
//
// Ports:
//   clk_Image_Process  in   clock, all logic on rising edge
//   Rst                in   synchronous active-high reset
//   RGB_VS             in   frame-start pulse
//   RGB_DE             in   pixel valid
//   Gate_In/Gate_Wr    in   threshold write data / strobe
//   Gray_Gate          out  active threshold, stable per frame
//   Pix_X/Pix_Y        out  coordinate of previously accepted pixel
//   Win_Valid          out  3x3 window centred on (Pix_X-1,Pix_Y-1) complete
//   Out_Valid          out  Win_Valid delayed by PIPE_DELAY clocks
//   Frame_Done         out  pulse after the last pixel of a frame
//   Line_Err           out  sticky line-length error
//
// Optional feature: define EDGE_CTRL_LINE_CHECK_EN to enable the
// line-length check and counter realignment. Otherwise Line_Err is 0.

module edge_window_ctrl #(
    parameter int         H_ACTIVE   = 1280,
    parameter int         V_ACTIVE   = 720,
    parameter int         CNT_W      = 11,
    parameter int         PIPE_DELAY = 2,
    parameter logic [7:0] GATE_INIT  = 8'd64
) (
    input  logic             clk_Image_Process,
    input  logic             Rst,
    input  logic             RGB_VS,
    input  logic             RGB_DE,
    input  logic [7:0]       Gate_In,
    input  logic             Gate_Wr,
    output logic [7:0]       Gray_Gate,
    output logic [CNT_W-1:0] Pix_X,
    output logic [CNT_W-1:0] Pix_Y,
    output logic             Win_Valid,
    output logic             Out_Valid,
    output logic             Frame_Done,
    output logic             Line_Err
);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] C_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0]      r_x;
    logic [CNT_W-1:0]      r_y;
    logic [CNT_W-1:0]      r_pix_x;
    logic [CNT_W-1:0]      r_pix_y;
    logic [7:0]            r_gate;
    logic [7:0]            r_pend;
    logic                  r_win;
    logic                  r_done;
    logic [PIPE_DELAY-1:0] r_pipe;

    logic             w_active;
    logic             w_acc;
    logic [CNT_W-1:0] w_cx;
    logic [CNT_W-1:0] w_cy;
    logic             w_x_last;
    logic             w_last_pix;
    logic             w_win_nxt;
    logic             w_done_nxt;

    assign w_active = (r_state == PRIME) || (r_state == RUN);

    // A DE on the VS cycle belongs to the new frame, so it is accepted
    // regardless of the current state and coordinates are forced to (0,0).
    assign w_acc      = RGB_DE && (RGB_VS || w_active);
    assign w_cx       = RGB_VS ? '0 : r_x;
    assign w_cy       = RGB_VS ? '0 : r_y;
    assign w_x_last   = (w_cx == X_LAST);
    assign w_last_pix = w_x_last && (w_cy == Y_LAST);

    always_ff @(posedge clk_Image_Process) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_state_nxt = r_state;
            end
            PRIME: begin
                if (w_acc && (w_cy == C_TWO) && (w_cx == '0)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_acc && !RGB_VS) begin
                    w_win_nxt  = (w_cx >= C_TWO) && (w_cy >= C_TWO);
                    w_done_nxt = w_last_pix;
                    if (w_last_pix) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = r_state;
            end
        endcase
        if (RGB_VS) begin
            w_state_nxt = PRIME;
        end
    end

`ifdef EDGE_CTRL_LINE_CHECK_EN
    logic r_de_d;
    logic r_line_err;
    logic w_line_bad;

    // A DE falling edge must land on a wrapped line (x back at 0).
    assign w_line_bad = w_active && r_de_d && !RGB_DE && (r_x != '0);

    always_ff @(posedge clk_Image_Process) begin
        if (Rst) begin
            r_de_d     <= 1'b0;
            r_line_err <= 1'b0;
        end else begin
            r_de_d <= RGB_DE;
            if (RGB_VS) begin
                r_line_err <= 1'b0;
            end else if (w_line_bad) begin
                r_line_err <= 1'b1;
            end
        end
    end

    assign Line_Err = r_line_err;
`else
    assign Line_Err = 1'b0;
`endif

    always_ff @(posedge clk_Image_Process) begin
        if (Rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_acc) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_cy + C_ONE;
            end else begin
                r_x <= w_cx + C_ONE;
                r_y <= w_cy;
            end
        end else if (RGB_VS) begin
            r_x <= '0;
            r_y <= '0;
`ifdef EDGE_CTRL_LINE_CHECK_EN
        end else if (w_line_bad) begin
            r_x <= '0;
            r_y <= r_y + C_ONE;
`endif
        end
    end

    always_ff @(posedge clk_Image_Process) begin
        if (Rst) begin
            r_pix_x <= '0;
            r_pix_y <= '0;
        end else if (w_acc) begin
            r_pix_x <= w_cx;
            r_pix_y <= w_cy;
        end
    end

    always_ff @(posedge clk_Image_Process) begin
        if (Rst) begin
            r_win  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_win  <= w_win_nxt;
            r_done <= w_done_nxt;
        end
    end

    // VS flushes the latency pipe so an aborted frame leaves no strobes.
    always_ff @(posedge clk_Image_Process) begin
        if (Rst || RGB_VS) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= r_win;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Write on the VS cycle bypasses the pending stage.
    always_ff @(posedge clk_Image_Process) begin
        if (Rst) begin
            r_gate <= GATE_INIT;
            r_pend <= GATE_INIT;
        end else begin
            if (Gate_Wr) begin
                r_pend <= Gate_In;
            end
            if (RGB_VS) begin
                r_gate <= Gate_Wr ? Gate_In : r_pend;
            end
        end
    end

    assign Gray_Gate  = r_gate;
    assign Pix_X      = r_pix_x;
    assign Pix_Y      = r_pix_y;
    assign Win_Valid  = r_win;
    assign Out_Valid  = r_pipe[PIPE_DELAY-1];
    assign Frame_Done = r_done;

endmodule

// File: tb/tb_edge_window_ctrl.sv
// tb_edge_window_ctrl: self-checking bench for edge_window_ctrl.
// Small 8x4 frame; table vectors for the threshold plus frame sequences.

module tb_edge_window_ctrl;

    localparam int         H  = 8;
    localparam int         V  = 4;
    localparam int         CW = 11;
    localparam int         PD = 2;
    localparam logic [7:0] GI = 8'h40;

`ifdef EDGE_CTRL_LINE_CHECK_EN
    localparam bit LCHK = 1'b1;
`else
    localparam bit LCHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          vs;
    logic          de;
    logic          wr;
    logic [7:0]    din;
    logic [7:0]    gate;
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic          win;
    logic          ov;
    logic          fd;
    logic          lerr;

    always #5 clk = ~clk;

    edge_window_ctrl #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .CNT_W     (CW),
        .PIPE_DELAY(PD),
        .GATE_INIT (GI)
    ) dut (
        .clk_Image_Process(clk),
        .Rst              (rst),
        .RGB_VS           (vs),
        .RGB_DE           (de),
        .Gate_In          (din),
        .Gate_Wr          (wr),
        .Gray_Gate        (gate),
        .Pix_X            (px),
        .Pix_Y            (py),
        .Win_Valid        (win),
        .Out_Valid        (ov),
        .Frame_Done       (fd),
        .Line_Err         (lerr)
    );

    typedef struct {
        logic [7:0] gate;
        int         px;
        int         py;
        bit         win;
        bit         fd;
        bit         ov;
        bit         lerr;
    } exp_t;

    typedef struct {
        bit         r;
        bit         v;
        bit         d;
        bit         w;
        logic [7:0] di;
        logic [7:0] gate;
    } vec_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;
    int c_win = 0;
    int c_fd  = 0;
    int c_ov  = 0;

    // reference model state (pixel index within frame)
    bit         m_act;
    int         m_k;
    bit         m_de_d;
    bit         m_wprev;
    bit         m_pipe[PD];
    logic [7:0] m_gate;
    logic [7:0] m_pend;
    int         m_px;
    int         m_py;
    bit         m_lerr;

    task automatic chk(string nm, int act, int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic void model(bit r, bit v, bit d, bit w, logic [7:0] di);
        exp_t e;
        bit   acc;
        int   x;
        int   y;
        e.win = 1'b0;
        e.fd  = 1'b0;
        if (r) begin
            m_act   = 1'b0;
            m_k     = 0;
            m_de_d  = 1'b0;
            m_wprev = 1'b0;
            m_gate  = GI;
            m_pend  = GI;
            m_px    = 0;
            m_py    = 0;
            m_lerr  = 1'b0;
            for (int i = 0; i < PD; i++) m_pipe[i] = 1'b0;
        end else begin
            acc = d && (v || m_act);
            if (v) begin
                m_act  = 1'b1;
                m_k    = 0;
                m_lerr = 1'b0;
            end else if (LCHK && m_act && m_de_d && !d && (m_k % H) != 0) begin
                m_lerr = 1'b1;
                m_k    = (m_k / H + 1) * H;
            end
            if (acc) begin
                x     = m_k % H;
                y     = m_k / H;
                m_px  = x;
                m_py  = y;
                e.win = (x >= 2) && (y >= 2);
                e.fd  = (m_k == H * V - 1);
                m_k++;
                if (e.fd) m_act = 1'b0;
            end
            m_de_d = d;
            if (v) m_gate = w ? di : m_pend;
            if (w) m_pend = di;
            if (v) begin
                for (int i = 0; i < PD; i++) m_pipe[i] = 1'b0;
            end else begin
                for (int i = PD - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
                m_pipe[0] = m_wprev;
            end
            m_wprev = e.win;
        end
        e.ov   = m_pipe[PD-1];
        e.gate = m_gate;
        e.px   = m_px;
        e.py   = m_py;
        e.lerr = m_lerr;
        sb.push_back(e);
    endfunction

    task automatic cyc(bit r, bit v, bit d, bit w, logic [7:0] di);
        exp_t e;
        rst = r;
        vs  = v;
        de  = d;
        wr  = w;
        din = di;
        model(r, v, d, w, di);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("Gray_Gate", int'(gate), int'(e.gate));
        chk("Pix_X", int'(px), e.px);
        chk("Pix_Y", int'(py), e.py);
        chk("Win_Valid", int'(win), int'(e.win));
        chk("Frame_Done", int'(fd), int'(e.fd));
        chk("Out_Valid", int'(ov), int'(e.ov));
        chk("Line_Err", int'(lerr), int'(e.lerr));
        c_win += int'(win);
        c_fd  += int'(fd);
        c_ov  += int'(ov);
    endtask

    task automatic clr_cnt();
        c_win = 0;
        c_fd  = 0;
        c_ov  = 0;
    endtask

    vec_t tv[11];

    initial begin
        tv[0]  = '{0, 1, 0, 0, 8'h00, 8'h40};
        tv[1]  = '{0, 0, 1, 0, 8'h00, 8'h40};
        tv[2]  = '{0, 0, 1, 1, 8'h50, 8'h40};
        tv[3]  = '{0, 0, 1, 0, 8'h00, 8'h40};
        tv[4]  = '{0, 0, 0, 0, 8'h00, 8'h40};
        tv[5]  = '{0, 1, 0, 0, 8'h00, 8'h50};
        tv[6]  = '{0, 0, 1, 0, 8'h00, 8'h50};
        tv[7]  = '{0, 1, 0, 1, 8'h90, 8'h90};
        tv[8]  = '{0, 0, 1, 0, 8'h00, 8'h90};
        tv[9]  = '{0, 0, 0, 1, 8'h33, 8'h90};
        tv[10] = '{0, 1, 0, 0, 8'h00, 8'h33};

        rst = 1'b1;
        vs  = 1'b0;
        de  = 1'b0;
        wr  = 1'b0;
        din = 8'h00;

        // reset
        repeat (3) cyc(1, 0, 0, 0, 8'h00);
        chk("rst_gate", int'(gate), 'h40);
        cyc(0, 0, 1, 0, 8'h00);
        chk("idle_de_ignored_x", int'(px), 0);

        // full frame, contiguous DE
        clr_cnt();
        cyc(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < H * V; i++) cyc(0, 0, 1, 0, 8'h00);
        repeat (4) cyc(0, 0, 0, 0, 8'h00);
        repeat (2) cyc(0, 0, 1, 0, 8'h00);
        chk("done_holds_pix_x", int'(px), H - 1);
        repeat (3) cyc(0, 0, 0, 0, 8'h00);
        chk("contig_win_cnt", c_win, 12);
        chk("contig_fd_cnt", c_fd, 1);
        chk("contig_ov_cnt", c_ov, 12);

        // threshold double buffering
        for (int i = 0; i < 11; i++) begin
            cyc(tv[i].r, tv[i].v, tv[i].d, tv[i].w, tv[i].di);
            chk($sformatf("tv%0d_gate", i), int'(gate), int'(tv[i].gate));
        end

        // abort after 13 pixels, VS with DE
        clr_cnt();
        cyc(0, 1, 0, 0, 8'h00);
        repeat (13) cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 1, 1, 0, 8'h00);
        chk("abort_vs_pix_x", int'(px), 0);
        chk("abort_vs_pix_y", int'(py), 0);
        // abort again once windows are in flight
        repeat (20) cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        chk("flush_ov", int'(ov), 0);
        repeat (3) cyc(0, 0, 0, 0, 8'h00);
        chk("abort_win_cnt", c_win, 3);
        chk("abort_ov_cnt", c_ov, 1);
        chk("abort_fd_cnt", c_fd, 0);

        // DE every other clock
        clr_cnt();
        cyc(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < H * V; i++) begin
            cyc(0, 0, 1, 0, 8'h00);
            cyc(0, 0, 0, 0, 8'h00);
        end
        repeat (3) cyc(0, 0, 0, 0, 8'h00);
`ifndef EDGE_CTRL_LINE_CHECK_EN
        chk("sparse_win_cnt", c_win, 12);
        chk("sparse_fd_cnt", c_fd, 1);
        chk("sparse_ov_cnt", c_ov, 12);
`endif

`ifdef EDGE_CTRL_LINE_CHECK_EN
        // short line
        cyc(0, 1, 0, 0, 8'h00);
        repeat (6) cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 0, 0, 0, 8'h00);
        chk("short_line_err", int'(lerr), 1);
        cyc(0, 0, 1, 0, 8'h00);
        chk("realign_x", int'(px), 0);
        chk("realign_y", int'(py), 1);
        repeat (7) cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        chk("vs_clears_err", int'(lerr), 0);
`endif

        // reset during RUN with VS and Gate_Wr
        cyc(0, 1, 0, 0, 8'h00);
        repeat (20) cyc(0, 0, 1, 0, 8'h00);
        cyc(1, 1, 1, 1, 8'hAA);
        chk("rst_run_gate", int'(gate), 'h40);
        chk("rst_run_x", int'(px), 0);
        repeat (5) cyc(0, 0, 1, 0, 8'h00);
        chk("rst_de_ignored_y", int'(py), 0);
        cyc(0, 1, 0, 0, 8'h00);
        chk("rst_vs_gate", int'(gate), 'h40);
        repeat (2) cyc(0, 0, 1, 0, 8'h00);
        chk("after_rst_x", int'(px), 1);
        repeat (3) cyc(0, 0, 0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
